fpga_cfg_loader: RTL and testbench

Configuration controller for the fpga fabric (8 LUTs, 5 switch boxes). It accepts a 15-word configuration stream over a valid/ready interface and writes each LUT memory (1 FF-select bit plus a 32-bit truth table) and each switch-box configure register (16 bits) through one-hot write strobes. It checks a trailing XOR checksum and enables the fabric only after a clean load. This replaces hierarchical poking of lt*/sb* state with a synthesizable load path.

---
 rtl/fpga_cfg_pkg.sv | 14 +
 rtl/cfg_csum_acc.sv | 13 +
 rtl/fpga_cfg_loader.sv | 98 +++++++++
 tb/tb_fpga_cfg_loader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared sizes, frame layout and loader state encoding
package fpga_cfg_pkg;
    localparam int N_LUT = 8;
    localparam int N_SB = 5;
    localparam int LUT_W = 32;
    localparam int SB_W = 16;
    localparam int FRAME_WORDS = N_LUT + N_SB + 2;
    localparam int OFS_MODE = 0;
    localparam int OFS_LUT = 1;
    localparam int OFS_SB = 1 + N_LUT;
    localparam int OFS_CSUM = FRAME_WORDS - 1;
    localparam int IDX_W = $clog2(N_LUT);
    typedef enum logic [2:0] {S_IDLE, S_MODE, S_LUT, S_SB, S_CHECK, S_DONE, S_ERROR} state_t;
endpackage

// File: rtl/cfg_csum_acc.sv
// cfg_csum_acc: 32-bit XOR accumulator with synchronous clear and enable
module cfg_csum_acc (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clock)
        if (reset || clr) q <= '0;
        else if (en) q <= q ^ d;
endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: streams a checksummed frame into LUT and switch-box config registers
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        cfg_data,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic [N_LUT-1:0]   lut_we,
    output logic [LUT_W:0]     lut_data,
    output logic [N_SB-1:0]    sb_we,
    output logic [SB_W-1:0]    sb_data,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               fabric_enable
);
    state_t state, next;
    logic [IDX_W-1:0] idx;
    logic [N_LUT-1:0] mode;
    logic [31:0] acc;
    logic beat, go, last_lut, last_sb;

    assign cfg_ready = state inside {S_MODE, S_LUT, S_SB, S_CHECK};
    assign busy = cfg_ready;
    assign beat = cfg_valid && cfg_ready;
    assign go = start && state inside {S_IDLE, S_DONE, S_ERROR};
    assign last_lut = idx == IDX_W'(N_LUT - 1);
    assign last_sb = idx == IDX_W'(N_SB - 1);
    assign fabric_enable = done;

    // the checksum word itself is compared, never folded in
    cfg_csum_acc u_acc (
        .clock(clock),
        .reset(reset),
        .clr(go),
        .en(beat && state != S_CHECK),
        .d(cfg_data),
        .q(acc)
    );

    always_ff @(posedge clock)
        if (reset) state <= S_IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: next = go ? S_MODE : state;
            S_MODE:  next = beat ? S_LUT : state;
            S_LUT:   next = beat && last_lut ? S_SB : state;
            S_SB:    next = beat && last_sb ? S_CHECK : state;
            S_CHECK: next = beat ? (cfg_data == acc ? S_DONE : S_ERROR) : state;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx <= '0;
            mode <= '0;
            lut_we <= '0;
            lut_data <= '0;
            sb_we <= '0;
            sb_data <= '0;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            lut_we <= beat && state == S_LUT ? N_LUT'(1) << idx : '0;
            sb_we <= beat && state == S_SB ? N_SB'(1) << idx : '0;
            if (go) begin
                idx <= '0;
                done <= 1'b0;
                error <= 1'b0;
            end
            if (beat) begin
                case (state)
                    S_MODE: mode <= cfg_data[N_LUT-1:0];
                    S_LUT: begin
                        lut_data <= {mode[idx], cfg_data};
                        idx <= last_lut ? '0 : idx + 1'b1;
                    end
                    S_SB: begin
                        sb_data <= cfg_data[SB_W-1:0];
                        idx <= last_sb ? '0 : idx + 1'b1;
                    end
                    S_CHECK: begin
                        done <= cfg_data == acc;
                        error <= cfg_data != acc;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: randomized frame loads checked against a frame-position reference model
module tb_fpga_cfg_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [31:0] cfg_data = '0;
    logic cfg_valid = 1'b0;
    logic cfg_ready, busy, done, error, fabric_enable;
    logic [7:0] lut_we;
    logic [32:0] lut_data;
    logic [4:0] sb_we;
    logic [15:0] sb_data;
    logic [31:0] frame [15];
    int checks = 0;
    int failures = 0;

    fpga_cfg_loader dut (
        .clock(clk), .reset(reset), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .lut_we(lut_we), .lut_data(lut_data), .sb_we(sb_we),
        .sb_data(sb_data), .busy(busy), .done(done), .error(error), .fabric_enable(fabric_enable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, cfg_ready, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_fen"}, fabric_enable, 0);
        chk({tag, "_we"}, {lut_we, sb_we}, 0);
        chk({tag, "_data"}, {lut_data, sb_data}, 0);
    endtask

    // word w of the frame, if accepted, must produce exactly its own strobe one cycle later
    task automatic check_strobes(input int w, input bit acc);
        logic [7:0] exp_lut;
        logic [4:0] exp_sb;
        exp_lut = (acc && w >= 1 && w <= 8) ? 8'(1) << (w - 1) : 8'd0;
        exp_sb = (acc && w >= 9 && w <= 13) ? 5'(1) << (w - 9) : 5'd0;
        chk("lut_we", lut_we, exp_lut);
        chk("sb_we", sb_we, exp_sb);
        if (exp_lut != 0) chk("lut_data", lut_data, {frame[0][w-1], frame[w]});
        if (exp_sb != 0) chk("sb_data", sb_data, frame[w][15:0]);
    endtask

    task automatic make_frame(input logic [31:0] w0, input bit corrupt);
        logic [31:0] x;
        frame[0] = w0;
        x = w0;
        for (int k = 1; k < 14; k++) begin
            frame[k] = $urandom;
            x ^= frame[k];
        end
        frame[14] = corrupt ? x ^ 32'h1 : x;
    endtask

    task automatic load(input int gap_pct, input bit sb_start, input int abort_after);
        int i, guard;
        bit v, good;
        logic [31:0] x;
        x = 0;
        for (int k = 0; k < 14; k++) x ^= frame[k];
        good = (x == frame[14]);
        start = 1;
        cfg_valid = 1;
        cfg_data = $urandom;
        chk("ready_before_start", cfg_ready, 0);
        tick();
        start = 0;
        chk("strobe_after_start", {lut_we, sb_we}, 0);
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("error_cleared", error, 0);
        chk("fen_cleared", fabric_enable, 0);
        i = 0;
        guard = 0;
        while (i < 15 && guard < 2000) begin
            guard++;
            v = $urandom_range(99) >= gap_pct;
            cfg_valid = v;
            cfg_data = v ? frame[i] : $urandom;
            start = sb_start && i == 10;
            chk("ready", cfg_ready, 1);
            tick();
            start = 0;
            check_strobes(i, v);
            if (v) i++;
            if (i < 15) chk("mid_flags", {done, error, fabric_enable}, 0);
            if (abort_after != 0 && i == abort_after) begin
                cfg_valid = 0;
                reset = 1;
                tick();
                reset = 0;
                check_reset("abort");
                tick();
                check_reset("post_abort");
                return;
            end
        end
        chk("load_guard", guard < 2000, 1);
        cfg_valid = 0;
        chk("done", done, good);
        chk("error", error, !good);
        chk("fen", fabric_enable, good);
        chk("busy_end", busy, 0);
        chk("ready_end", cfg_ready, 0);
        tick();
        chk("done_hold", done, good);
        chk("error_hold", error, !good);
        chk("strobe_idle", {lut_we, sb_we}, 0);
    endtask

    initial begin
        repeat (3) tick();
        reset = 0;
        check_reset("reset");
        tick();
        check_reset("after_reset");

        make_frame(32'h8000_0000, 0);
        load(0, 0, 0);
        make_frame(32'h0000_0008, 0);
        load(0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            make_frame($urandom, 0);
            load(30, 0, 0);
        end
        make_frame($urandom, 1);
        load(0, 0, 0);
        make_frame($urandom, 0);
        load(20, 0, 0);
        make_frame($urandom, 0);
        load(0, 0, 6);
        load(0, 0, 0);
        make_frame($urandom, 0);
        load(0, 1, 0);
        make_frame($urandom, 1);
        load(30, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
